// File: rtl/execute_pipe.sv
// execute_pipe: registered MIPS execute stage with valid/ready handshakes on both sides.
// Define EXECUTE_MULT_EN to build the iterative multiplier with HI/LO, mfhi/mflo and busy.
module execute_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data_1,
    input  logic [WIDTH-1:0] read_data_2,
    input  logic [WIDTH-1:0] extended_address,
    input  logic [WIDTH-1:0] next_address,
    input  logic [1:0]       ALU_op,
    input  logic             ALU_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic [WIDTH-1:0] new_address,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal,
    output logic             busy
);
    // Narrow datapaths cannot hold all five shamt bits; use what fits.
    localparam int SH_TOP = (WIDTH > 10) ? 10 : WIDTH - 1;

    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  branch_target;
    logic [5:0]        funct;
    logic [SH_TOP-6:0] shamt;
    logic              alu_illegal;
    logic              accept;

    assign op_b          = ALU_src ? extended_address : read_data_2;
    assign funct         = extended_address[5:0];
    assign shamt         = extended_address[SH_TOP:6];
    assign branch_target = next_address + (extended_address << 2);
    assign in_ready      = !busy && (!out_valid || out_ready);
    assign accept        = in_valid && in_ready;
    assign zero          = (ALU_result == '0);

`ifdef EXECUTE_MULT_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_final;
    logic [WIDTH:0]     step_sum;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               negate;
    logic               start_mul;
    logic               mul_signed;

    // The product is built on magnitudes; the sign is restored once in DONE.
    assign mag_a      = (mul_signed && read_data_1[WIDTH-1]) ? -read_data_1 : read_data_1;
    assign mag_b      = (mul_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign step_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{prod[0]}}};
    assign prod_final = negate ? -prod : prod;
    assign busy       = (state != ST_IDLE);
`else
    assign hi   = '0;
    assign lo   = '0;
    assign busy = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
`ifdef EXECUTE_MULT_EN
        start_mul   = 1'b0;
        mul_signed  = 1'b0;
`endif
        case (ALU_op)
            2'b00: alu_res = read_data_1 + op_b;
            2'b01: alu_res = read_data_1 - op_b;
            2'b11: alu_res = {{(WIDTH-1){1'b0}}, $signed(read_data_1) < $signed(op_b)};
            default: begin
                case (funct)
                    6'b100000: alu_res = read_data_1 + op_b;
                    6'b100010: alu_res = read_data_1 - op_b;
                    6'b100100: alu_res = read_data_1 & op_b;
                    6'b100101: alu_res = read_data_1 | op_b;
                    6'b100110: alu_res = read_data_1 ^ op_b;
                    6'b100111: alu_res = ~(read_data_1 | op_b);
                    6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(read_data_1) < $signed(op_b)};
                    6'b101011: alu_res = {{(WIDTH-1){1'b0}}, read_data_1 < op_b};
                    6'b000000: alu_res = read_data_2 << shamt;
                    6'b000010: alu_res = read_data_2 >> shamt;
                    6'b000011: alu_res = $signed(read_data_2) >>> shamt;
`ifdef EXECUTE_MULT_EN
                    6'b010000: alu_res = hi;
                    6'b010010: alu_res = lo;
                    6'b011000: begin
                        start_mul  = 1'b1;
                        mul_signed = 1'b1;
                    end
                    6'b011001: start_mul = 1'b1;
`endif
                    default:   alu_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // NOTE: state is updated with <= only, so every read in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            ALU_result  <= '0;
            new_address <= '0;
            illegal     <= 1'b0;
`ifdef EXECUTE_MULT_EN
            state       <= ST_IDLE;
            count       <= '0;
            mcand       <= '0;
            prod        <= '0;
            negate      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`endif
        end else begin
            if (accept) begin
                new_address <= branch_target;
                out_valid   <= 1'b1;
                ALU_result  <= alu_res;
                illegal     <= alu_illegal;
`ifdef EXECUTE_MULT_EN
                if (start_mul) begin
                    out_valid <= 1'b0;
                    state     <= ST_MUL;
                    count     <= '0;
                    mcand     <= mag_a;
                    prod      <= {{WIDTH{1'b0}}, mag_b};
                    negate    <= mul_signed && (read_data_1[WIDTH-1] ^ op_b[WIDTH-1]);
                end
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef EXECUTE_MULT_EN
            // in_ready is low while busy, so these never collide with an accept.
            case (state)
                ST_MUL: begin
                    prod  <= {step_sum, prod[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    hi         <= prod_final[2*WIDTH-1:WIDTH];
                    lo         <= prod_final[WIDTH-1:0];
                    ALU_result <= prod_final[WIDTH-1:0];
                    illegal    <= 1'b0;
                    out_valid  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: ;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: randomized and directed bench for execute_pipe against a
// transaction-level model that tracks results, hi/lo and multiplier latency.
module tb_execute_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] read_data_1;
    logic [W-1:0] read_data_2;
    logic [W-1:0] extended_address;
    logic [W-1:0] next_address;
    logic [1:0]   ALU_op;
    logic         ALU_src;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_result;
    logic         zero;
    logic [W-1:0] new_address;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         illegal;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en     = 1'b0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    execute_pipe #(.WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .read_data_1      (read_data_1),
        .read_data_2      (read_data_2),
        .extended_address (extended_address),
        .next_address     (next_address),
        .ALU_op           (ALU_op),
        .ALU_src          (ALU_src),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .ALU_result       (ALU_result),
        .zero             (zero),
        .new_address      (new_address),
        .hi               (hi),
        .lo               (lo),
        .illegal          (illegal),
        .busy             (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state: the visible result plus a countdown for a pending multiply.
    logic         m_valid;
    logic [W-1:0] m_result, m_new, m_hi, m_lo, p_hi, p_lo;
    logic         m_illegal;
    int           m_busy_left;

    task automatic ref_exec(input logic [1:0] op, input logic src, input logic [W-1:0] a,
                            input logic [W-1:0] rt, input logic [W-1:0] ext,
                            output logic [W-1:0] res, output logic ill,
                            output logic is_mul, output logic [2*W-1:0] prod);
        logic [W-1:0] b;
        int sh;
        b = src ? ext : rt;
        sh = int'(ext[10:6]);
        res = '0;
        ill = 1'b0;
        is_mul = 1'b0;
        prod = '0;
        case (op)
            2'b00: res = a + b;
            2'b01: res = a - b;
            2'b11: res = ($signed(a) < $signed(b)) ? 1 : 0;
            default: begin
                case (ext[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    6'h2B: res = (a < b) ? 1 : 0;
                    6'h00: res = rt << sh;
                    6'h02: res = rt >> sh;
                    6'h03: res = $signed(rt) >>> sh;
`ifdef EXECUTE_MULT_EN
                    6'h10: res = m_hi;
                    6'h12: res = m_lo;
                    6'h18: begin
                        is_mul = 1'b1;
                        prod = longint'($signed(a)) * longint'($signed(b));
                    end
                    6'h19: begin
                        is_mul = 1'b1;
                        prod = {32'h0, a} * {32'h0, b};
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
        endcase
    endtask

    always @(posedge clk) begin
        logic         rdy;
        logic [W-1:0] r;
        logic         il;
        logic         mul;
        logic [2*W-1:0] pr;
        int           old_busy;
        if (reset) begin
            m_valid = 1'b0;
            m_result = '0;
            m_new = '0;
            m_hi = '0;
            m_lo = '0;
            m_illegal = 1'b0;
            m_busy_left = 0;
        end else begin
            old_busy = m_busy_left;
            rdy = (m_busy_left == 0) && (!m_valid || out_ready);
            if (in_valid && rdy) begin
                ref_exec(ALU_op, ALU_src, read_data_1, read_data_2, extended_address, r, il, mul, pr);
                m_new = next_address + extended_address * 4;
                if (mul) begin
                    m_valid = 1'b0;
                    m_busy_left = W + 1;
                    p_hi = pr[2*W-1:W];
                    p_lo = pr[W-1:0];
                end else begin
                    m_valid = 1'b1;
                    m_result = r;
                    m_illegal = il;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (old_busy > 0) begin
                m_busy_left = old_busy - 1;
                if (m_busy_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_result = p_lo;
                    m_illegal = 1'b0;
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Single compare process: every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("out_valid", out_valid, m_valid);
            check("busy", busy, m_busy_left > 0);
            check("in_ready", in_ready, (m_busy_left == 0) && (!m_valid || out_ready));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (m_valid) begin
                check("ALU_result", ALU_result, m_result);
                check("zero", zero, m_result == '0);
                check("illegal", illegal, m_illegal);
                check("new_address", new_address, m_new);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic src, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ext, input logic [W-1:0] nxt);
        int guard;
        guard = 0;
        @(negedge clk);
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_wait: in_ready=0 after %0d cycles, required 1", guard);
        end
        ALU_op = op;
        ALU_src = src;
        read_data_1 = a;
        read_data_2 = b;
        extended_address = ext;
        next_address = nxt;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 60);
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0: return W'($urandom);
            1: return W'($urandom_range(0, 15));
            2: return 32'h8000_0000;
            default: return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] functs [17];
        int n;
        bit seen;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00,
                   6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h3F, 6'h01};
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ALU_op = 2'b00;
        ALU_src = 1'b0;
        read_data_1 = '0;
        read_data_2 = '0;
        extended_address = '0;
        next_address = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        reset = 1'b0;

        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", ALU_result, 0);
        check("rst_zero", zero, 1);
        check("rst_new_address", new_address, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        send(2'b10, 1'b0, 32'd5, 32'd5, 32'h22, 32'h1000);
        @(posedge clk); #1;
        check("sub_valid", out_valid, 1);
        check("sub_result", ALU_result, 0);
        check("sub_zero", zero, 1);
        check("sub_new_address", new_address, 32'h1088);

        send(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'h0);
        @(posedge clk); #1;
        check("slt_result", ALU_result, 1);
        check("slt_zero", zero, 0);
        send(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2B, 32'h0);
        @(posedge clk); #1;
        check("sltu_result", ALU_result, 0);

        send(2'b01, 1'b0, 32'd9, 32'd4, 32'hFFFF_FFFF, 32'h100);
        @(posedge clk); #1;
        check("branch_new_address", new_address, 32'hFC);
        check("branch_sub_result", ALU_result, 5);

        send(2'b10, 1'b0, 32'd7, 32'd9, 32'h3F, 32'h0);
        @(posedge clk); #1;
        check("bad_funct_illegal", illegal, 1);
        check("bad_funct_result", ALU_result, 0);
        check("bad_funct_valid", out_valid, 1);

`ifdef EXECUTE_MULT_EN
        send(2'b10, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h18, 32'h0);
        @(posedge clk); #1;
        check("mult_busy_start", busy, 1);
        idle();
        wait_result(n);
        check("mult_latency", n, W + 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_result", ALU_result, 32'hFFFF_FFEB);
        check("mult_busy_done", busy, 0);
        send(2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h19, 32'h0);
        idle();
        wait_result(n);
        check("multu_latency", n, W + 1);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h1);
        send(2'b10, 1'b0, 32'h0, 32'h0, 32'h10, 32'h0);
        @(posedge clk); #1;
        check("mfhi_result", ALU_result, 32'hFFFF_FFFE);
`else
        send(2'b10, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h18, 32'h0);
        @(posedge clk); #1;
        check("mult_off_illegal", illegal, 1);
        check("mult_off_result", ALU_result, 0);
        check("mult_off_busy", busy, 0);
        check("mult_off_valid", out_valid, 1);
`endif

        send(2'b00, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("stall_first", ALU_result, 3);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_result", ALU_result, 3);
            check("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 1'b0, W'(i), 32'd10, 32'h0, 32'h0);
            @(posedge clk); #1;
            check("b2b_valid", out_valid, 1);
            check("b2b_result", ALU_result, W'(i + 10));
        end

`ifdef EXECUTE_MULT_EN
        send(2'b10, 1'b0, 32'd3, 32'd5, 32'h18, 32'h0);
`else
        send(2'b00, 1'b0, 32'd3, 32'd5, 32'h0, 32'h0);
`endif
        idle();
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_valid", out_valid, 0);
        check("abort_result", ALU_result, 0);
        seen = 1'b0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 0);

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [1:0]   op;
            logic [W-1:0] ext;
            op = $urandom_range(0, 1) ? 2'b10 : 2'(W'($urandom_range(0, 3)));
            ext = W'($urandom);
            if (op == 2'b10) ext[5:0] = functs[$urandom_range(0, 16)];
            send(op, 1'($urandom_range(0, 1)), rand_word(), rand_word(), ext, W'($urandom));
        end
        idle();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (W + 5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
